// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller for a 5-stage RV32 core. Generates
//            stall/flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB
//            pipeline registers, selects EX-stage operand forwarding,
//            sequences multi-cycle data-memory waits with a timeout FSM and
//            keeps saturating stall/flush event counters for debug.
// Ports    :
//   CLK, RST                 clock (rising edge), async active-high reset
//   Rs1_D, Rs2_D             ID-stage source registers
//   Rs1_E, Rs2_E, Rd_E       EX-stage source/destination registers
//   ResultSrcE0, PCSrcE      EX instruction is a load / branch taken
//   Rd_M, RegWriteM          MEM-stage destination and write enable
//   MemReqM, MemReadyM       data-memory request / completion
//   Rd_W, RegWriteW          WB-stage destination and write enable
//   StallF/D/E/M             hold PC, IF/ID, ID/EX, EX/MEM
//   FlushD/E/W               clear IF/ID, ID/EX, MEM/WB
//   ForwardAE/BE             SrcA/SrcB select: 00 RF, 01 WB, 10 MEM
//   MemErr                   sticky memory timeout flag
//   StallCnt, FlushCnt       saturating event counters
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic [4:0]       Rd_M,
  input  logic             RegWriteM,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic [4:0]       Rd_W,
  input  logic             RegWriteW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  localparam logic [7:0]       C_TIMEOUT = 8'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       w_mem_wait;
  logic       w_lw_stall;
  logic [7:0] w_wcnt_inc;
  logic [1:0] w_fwd_a, w_fwd_b;
  logic       w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic       w_flush_d, w_flush_e, w_flush_w, w_mem_err;

  assign w_mem_wait = MemReqM & ~MemReadyM;
  assign w_lw_stall = ResultSrcE0 & (Rd_E != 5'd0) &
                      ((Rd_E == Rs1_D) | (Rd_E == Rs2_D));
  assign w_wcnt_inc = wcnt_q + 8'd1;

  // MEM result is younger than WB, so it takes priority.
  always_comb begin
    w_fwd_a = 2'b00;
    if (RegWriteM && (Rd_M != 5'd0) && (Rd_M == Rs1_E))
      w_fwd_a = 2'b10;
    else if (RegWriteW && (Rd_W != 5'd0) && (Rd_W == Rs1_E))
      w_fwd_a = 2'b01;
  end

  always_comb begin
    w_fwd_b = 2'b00;
    if (RegWriteM && (Rd_M != 5'd0) && (Rd_M == Rs2_E))
      w_fwd_b = 2'b10;
    else if (RegWriteW && (Rd_W != 5'd0) && (Rd_W == Rs2_E))
      w_fwd_b = 2'b01;
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_w = 1'b0;
    w_mem_err = 1'b0;
    case (state_q)
      S_RUN, S_WAIT: begin
        if (w_mem_wait) begin
          // Freeze the whole front of the pipe and bubble WB; a taken
          // branch in EX stays held until memory completes.
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_stall_e = 1'b1;
          w_stall_m = 1'b1;
          w_flush_w = 1'b1;
          // The first wait cycle (seen in RUN) already counts as one.
          wcnt_d    = (state_q == S_RUN) ? 8'd1 : w_wcnt_inc;
          if (wcnt_d >= C_TIMEOUT)
            state_d = S_ERR;
          else
            state_d = S_WAIT;
        end else begin
          state_d = S_RUN;
          wcnt_d  = 8'd0;
          if (PCSrcE) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
          end else if (w_lw_stall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
          end
        end
      end
      S_ERR: begin
        // Terminal until reset; memory readiness no longer matters.
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_stall_m = 1'b1;
        w_flush_w = 1'b1;
        w_mem_err = 1'b1;
      end
      default: begin
        state_d = S_RUN;
        wcnt_d  = 8'd0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (w_stall_f && (stall_cnt_q != C_CNT_MAX))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (w_flush_e && (flush_cnt_q != C_CNT_MAX))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_RUN;
      wcnt_q      <= 8'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Outputs are combinational from inputs, so reset must mask them directly
  // for them to drop immediately on an asynchronous reset.
  always_comb begin
    StallF    = w_stall_f & ~RST;
    StallD    = w_stall_d & ~RST;
    StallE    = w_stall_e & ~RST;
    StallM    = w_stall_m & ~RST;
    FlushD    = w_flush_d & ~RST;
    FlushE    = w_flush_e & ~RST;
    FlushW    = w_flush_w & ~RST;
    MemErr    = w_mem_err & ~RST;
    ForwardAE = RST ? 2'b00 : w_fwd_a;
    ForwardBE = RST ? 2'b00 : w_fwd_b;
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule
`default_nettype wire
